// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, saturates to all nines when the value cannot be shown.
module seq_bin2bcd #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    // Wide enough for both the input and 10^DIGITS, so the overflow compare never truncates.
    localparam int CMP_W = ((BIN_W > BCD_W + 1) ? BIN_W : BCD_W + 1) + 1;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    function automatic logic [CMP_W-1:0] pow10(input int n);
        logic [CMP_W-1:0] r;
        r = CMP_W'(1);
        for (int i = 0; i < n; i++) begin
            r = (r << 3) + (r << 1);
        end
        return r;
    endfunction

    localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);

    // Add 3 to every nibble that is 5 or more; each nibble is adjusted on its own.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            nib = s[4*d +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*d +: 4] = nib;
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] s, input logic sat);
        return sat ? {DIGITS{4'h9}} : s;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             shift_en;
    logic             load_en;

    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] scratch;
    logic             sat;
    logic [CNT_W-1:0] cnt;

    logic [BCD_W+BIN_W-1:0] step_cat;
    logic                   sat_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) && start;
        shift_en = (state == SHIFT);
        load_en  = (state == LOAD);
    end

    always_comb begin
        step_cat = {add3_all(scratch), shreg} << 1;
        sat_in   = (CMP_W'(bin) >= LIMIT);
    end

    // Datapath: shift register, scratch digits, bit counter and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            sat     <= 1'b0;
            cnt     <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= load_en;
            if (accept) begin
                shreg   <= bin;
                scratch <= '0;
                sat     <= sat_in;
                cnt     <= CNT_W'(BIN_W - 1);
            end else if (shift_en) begin
                scratch <= step_cat[BCD_W+BIN_W-1 -: BCD_W];
                shreg   <= step_cat[BIN_W-1:0];
                cnt     <= cnt - 1'b1;
            end
            if (load_en) begin
                bcd <= saturate(scratch, sat);
                ovf <= sat;
            end
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: the driver queues expected results,
// a monitor compares them whenever done pulses.
module tb_seq_bin2bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [32:0] exp_q[$];

    seq_bin2bcd #(.BIN_W(27), .DIGITS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always begin
        logic [32:0] e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got bcd %0h with nothing expected", bcd);
            end else begin
                e = exp_q.pop_front();
                chk("bcd", {32'd0, bcd}, {32'd0, e[32:1]});
                chk("ovf", {63'd0, ovf}, {63'd0, e[0]});
            end
        end
    end

    // Counts edges until done is seen (bounded); optionally pulses start mid-conversion.
    task automatic wait_done(input int pulse_at, output int n, output int bhigh);
        logic [31:0] held;
        logic        moved;
        held  = bcd;
        moved = 1'b0;
        n     = 0;
        bhigh = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bhigh++;
            if (!done && bcd !== held) moved = 1'b1;
            if (n == pulse_at) begin
                start = 1'b1;
                bin   = 27'd7;
            end else if (pulse_at > 0 && n == pulse_at + 1) begin
                start = 1'b0;
            end
        end while (!done && n < 100);
        chk("hold_between_done", {63'd0, moved}, 64'd0);
    endtask

    task automatic run(input logic [26:0] v, input logic [31:0] eb, input logic eo,
                       input int pulse_at);
        int n;
        int b1;
        int b2;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        exp_q.push_back({eb, eo});
        #1;
        start = 1'b0;
        b1 = busy ? 1 : 0;
        wait_done(pulse_at, n, b2);
        chk("latency", 64'(n), 64'd28);
        chk("busy_cycles", 64'(b1 + b2), 64'd28);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   bh;
        int   dc;
        logic bad;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bcd",  {32'd0, bcd},  64'd0);
        chk("reset_ovf",  {63'd0, ovf},  64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(27'd0,         32'h00000000, 1'b0, 0);
        run(27'd12345678,  32'h12345678, 1'b0, 0);
        run(27'd99999999,  32'h99999999, 1'b0, 0);
        run(27'd100000000, 32'h99999999, 1'b1, 0);
        run(27'h7FFFFFF,   32'h99999999, 1'b1, 0);

        // Second start while busy (with bin changed to 7) must be ignored.
        run(27'd42, 32'h00000042, 1'b0, 10);
        dc = done_cnt;
        repeat (35) @(posedge clk);
        #1;
        chk("no_extra_done", 64'(done_cnt), 64'(dc));

        // Reset in the middle of a conversion aborts it silently.
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd305;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_bcd",  {32'd0, bcd},  64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (busy || done || bcd != 32'd0) bad = 1'b1;
        end
        chk("abort_quiet", {63'd0, bad}, 64'd0);
        run(27'd9, 32'h00000009, 1'b0, 0);

        // start held high: each done cycle re-accepts, giving a 29-cycle period.
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd1;
        @(posedge clk);
        exp_q.push_back({32'h00000001, 1'b0});
        #1;
        wait_done(0, n, bh);
        chk("b2b_first_latency", 64'(n), 64'd28);
        bin = 27'd2;
        exp_q.push_back({32'h00000002, 1'b0});
        wait_done(0, n, bh);
        chk("b2b_period_2", 64'(n), 64'd29);
        bin = 27'd3;
        exp_q.push_back({32'h00000003, 1'b0});
        wait_done(0, n, bh);
        chk("b2b_period_3", 64'(n), 64'd29);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
